// File: rtl/dsp_ax_dispatcher_if.sv
// Master AW/AR request channel: address payload plus valid/ready.
// master drives payload/valid, slave returns ready.
interface dsp_ax_dispatcher_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_W       = 5,
   parameter int BURST_W    = 2,
   parameter int LEN_W      = 8,
   parameter int SIZE_W     = 3
);
   logic [ID_W-1:0]       AxID;
   logic [ADDR_WIDTH-1:0] AxADDR;
   logic [BURST_W-1:0]    AxBURST;
   logic [LEN_W-1:0]      AxLEN;
   logic [SIZE_W-1:0]     AxSIZE;
   logic                  AxVALID;
   logic                  AxREADY;

   modport master (
      output AxID, AxADDR, AxBURST, AxLEN, AxSIZE, AxVALID,
      input  AxREADY
   );

   modport slave (
      input  AxID, AxADDR, AxBURST, AxLEN, AxSIZE, AxVALID,
      output AxREADY
   );
endinterface

// File: rtl/dsp_ax_dispatcher.sv
// Per-master AW/AR dispatcher: skid-buffers the request, decodes the slave,
// issues one-hot valid, tracks {err,slv,len} order FIFO and data beats.
module dsp_ax_dispatcher #(
   parameter int SLV_AMT           = 3,
   parameter int OUTSTANDING_AMT   = 8,
   parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
   parameter int ADDR_WIDTH        = 32,
   parameter int TRANS_MST_ID_W    = 5,
   parameter int TRANS_BURST_W     = 2,
   parameter int TRANS_DATA_LEN_W  = 8,
   parameter int TRANS_DATA_SIZE_W = 3,
   parameter int SLV_ID_W          = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
   parameter int SLV_ID_LSB_IDX    = 28,
   parameter bit SLV_SWITCH_STALL  = 1'b1
) (
   input  logic                                    ACLK_i,
   input  logic                                    ARESET_i,
   dsp_ax_dispatcher_if.slave                      m_if,
   input  logic                                    m_xVALID_i,
   input  logic                                    m_xREADY_i,
   input  logic [SLV_AMT-1:0]                      sa_AxREADY_i,
   output logic [TRANS_MST_ID_W*SLV_AMT-1:0]       sa_AxID_o,
   output logic [ADDR_WIDTH*SLV_AMT-1:0]           sa_AxADDR_o,
   output logic [TRANS_BURST_W*SLV_AMT-1:0]        sa_AxBURST_o,
   output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]     sa_AxLEN_o,
   output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]    sa_AxSIZE_o,
   output logic [SLV_AMT-1:0]                      sa_AxVALID_o,
   output logic [OUTST_CTN_W-1:0]                  sa_Ax_outst_ctn_o,
   output logic [SLV_ID_W-1:0]                     dsp_xDATA_slv_id_o,
   output logic                                    dsp_xDATA_err_o,
   output logic                                    dsp_xDATA_last_o,
   output logic                                    dsp_xDATA_disable_o,
   output logic [SLV_ID_W-1:0]                     dsp_WRESP_slv_id_o,
   output logic                                    dsp_WRESP_err_o,
   output logic                                    dsp_WRESP_shift_en_o
);

   localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
   localparam logic [OUTST_CTN_W-1:0] DEPTH_C = OUTST_CTN_W'(OUTSTANDING_AMT);
   localparam logic [SLV_ID_W:0] SLV_AMT_C = (SLV_ID_W+1)'(SLV_AMT);
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(OUTSTANDING_AMT - 1);

   typedef struct packed {
      logic [TRANS_MST_ID_W-1:0]    id;
      logic [ADDR_WIDTH-1:0]        addr;
      logic [TRANS_BURST_W-1:0]     burst;
      logic [TRANS_DATA_LEN_W-1:0]  len;
      logic [TRANS_DATA_SIZE_W-1:0] size;
   } req_t;

   typedef struct packed {
      logic                        err;
      logic [SLV_ID_W-1:0]         slv;
      logic [TRANS_DATA_LEN_W-1:0] len;
   } ord_t;

   req_t                        req_in;
   req_t                        head_q, head_d, skid_q, skid_d;
   logic                        head_vld_q, head_vld_d;
   logic                        skid_vld_q, skid_vld_d;
   ord_t                        mem_q [OUTSTANDING_AMT];
   ord_t                        mem_d [OUTSTANDING_AMT];
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OUTST_CTN_W-1:0]      cnt_q, cnt_d;
   logic [TRANS_DATA_LEN_W-1:0] beat_ctn_q, beat_ctn_d;
   logic [SLV_ID_W-1:0]         last_slv_q, last_slv_d;

   logic [SLV_ID_W-1:0] idx;
   logic                dec_err, fifo_empty, fifo_full, stall, issue;
   logic                accept, consume, beat, pop, is_last;
   logic [SLV_AMT-1:0]  sa_vld;
   ord_t                ord_head;

   // Ready depends only on skid occupancy, never on slave ready.
   assign m_if.AxREADY = ~skid_vld_q & ~ARESET_i;
   assign accept       = m_if.AxVALID & m_if.AxREADY;

   assign req_in = '{id: m_if.AxID, addr: m_if.AxADDR, burst: m_if.AxBURST,
                     len: m_if.AxLEN, size: m_if.AxSIZE};

   always_comb begin
      idx        = head_q.addr[SLV_ID_LSB_IDX +: SLV_ID_W];
      dec_err    = {1'b0, idx} >= SLV_AMT_C;
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == DEPTH_C);
      // Slave switch waits until every outstanding transfer retired.
      stall      = SLV_SWITCH_STALL & ~fifo_empty & (idx != last_slv_q) & ~dec_err;
      issue      = head_vld_q & ~fifo_full & ~stall;
      sa_vld     = '0;
      for (int s = 0; s < SLV_AMT; s++) begin
         sa_vld[s] = issue & ~dec_err & (idx == SLV_ID_W'(s));
      end
      consume    = issue & (dec_err | (|(sa_vld & sa_AxREADY_i)));
      ord_head   = mem_q[rd_ptr_q];
      beat       = m_xVALID_i & m_xREADY_i & ~fifo_empty;
      is_last    = ~fifo_empty & (beat_ctn_q == ord_head.len);
      pop        = beat & is_last;

      head_vld_d = head_vld_q;
      head_d     = head_q;
      skid_vld_d = skid_vld_q;
      skid_d     = skid_q;
      if (~head_vld_q | consume) begin
         if (skid_vld_q) begin
            head_vld_d = 1'b1;
            head_d     = skid_q;
            skid_vld_d = 1'b0;
         end else begin
            head_vld_d = accept;
            if (accept) head_d = req_in;
         end
      end else if (accept) begin
         skid_vld_d = 1'b1;
         skid_d     = req_in;
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (consume) begin
         mem_d[wr_ptr_q] = '{err: dec_err, slv: idx, len: head_q.len};
         wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      cnt_d = cnt_q + OUTST_CTN_W'(consume) - OUTST_CTN_W'(pop);

      last_slv_d = (consume & ~dec_err) ? idx : last_slv_q;

      beat_ctn_d = beat_ctn_q;
      if (pop)       beat_ctn_d = '0;
      else if (beat) beat_ctn_d = beat_ctn_q + TRANS_DATA_LEN_W'(1);
   end

   always_ff @(posedge ACLK_i) begin
      if (ARESET_i) begin
         head_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         head_q     <= '0;
         skid_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         beat_ctn_q <= '0;
         last_slv_q <= '0;
      end else begin
         head_vld_q <= head_vld_d;
         skid_vld_q <= skid_vld_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         beat_ctn_q <= beat_ctn_d;
         last_slv_q <= last_slv_d;
      end
   end

   // Entry storage needs no reset: reads are masked by the empty flag.
   always_ff @(posedge ACLK_i) begin
      mem_q <= mem_d;
   end

   assign sa_AxID_o    = {SLV_AMT{head_q.id}};
   assign sa_AxADDR_o  = {SLV_AMT{head_q.addr}};
   assign sa_AxBURST_o = {SLV_AMT{head_q.burst}};
   assign sa_AxLEN_o   = {SLV_AMT{head_q.len}};
   assign sa_AxSIZE_o  = {SLV_AMT{head_q.size}};
   assign sa_AxVALID_o = sa_vld;

   assign sa_Ax_outst_ctn_o    = cnt_q;
   assign dsp_xDATA_slv_id_o   = fifo_empty ? '0 : ord_head.slv;
   assign dsp_xDATA_err_o      = ~fifo_empty & ord_head.err;
   assign dsp_xDATA_last_o     = is_last;
   assign dsp_xDATA_disable_o  = fifo_empty;
   assign dsp_WRESP_slv_id_o   = fifo_empty ? '0 : ord_head.slv;
   assign dsp_WRESP_err_o      = ~fifo_empty & ord_head.err;
   assign dsp_WRESP_shift_en_o = pop;

endmodule
